// File: rtl/core_ctrl_pkg.sv
// Shared constants, instruction bit map and phase encoding for the core sequencer.
package core_ctrl_pkg;

  localparam int INST_W  = 34;
  localparam int AW      = 11;
  localparam int CNT_W   = 8;

  localparam int COL     = 8;
  localparam int LEN_NIJ = 36;
  localparam int LEN_KIJ = 9;
  localparam int GAP_CYC = 12;

  localparam logic [AW-1:0] W_BASE = 11'h400;
  localparam logic [AW-1:0] A_BASE = 11'h000;

  localparam int BIT_ACC        = 33;
  localparam int BIT_CEN_PMEM   = 32;
  localparam int BIT_WEN_PMEM   = 31;
  localparam int BIT_A_PMEM_LSB = 20;
  localparam int BIT_CEN_XMEM   = 19;
  localparam int BIT_WEN_XMEM   = 18;
  localparam int BIT_A_XMEM_LSB = 7;
  localparam int BIT_OFIFO_RD   = 6;
  localparam int BIT_IFIFO_WR   = 5;
  localparam int BIT_IFIFO_RD   = 4;
  localparam int BIT_L0_RD      = 3;
  localparam int BIT_L0_WR      = 2;
  localparam int BIT_EXECUTE    = 1;
  localparam int BIT_LOAD       = 0;

  // Both memories deselected with write-enable inactive; everything else low.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_L0  = 3'd1,
    LOAD  = 3'd2,
    GAP   = 3'd3,
    A_L0  = 3'd4,
    EXEC  = 3'd5,
    DRAIN = 3'd6,
    FIN   = 3'd7
  } phase_e;

endpackage

// File: rtl/xmem_rd_stream.sv
// Streams len consecutive xmem reads from base; l0_wr trails the read by the
// one-cycle SRAM latency, and last marks the cycle that catches the final word.
module xmem_rd_stream
  import core_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [AW-1:0]    base,
  input  logic [CNT_W-1:0] len,
  output logic             cen,
  output logic [AW-1:0]    addr,
  output logic             l0_wr,
  output logic             last
);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic             rd_q, rd_d;

  always_comb begin
    rd_d  = go && (idx_q < len);
    idx_d = go ? idx_q + CNT_W'(1) : '0;
    cen   = ~rd_d;
    addr  = rd_d ? base + AW'(idx_q) : '0;
    l0_wr = rd_q;
    last  = go && (idx_q == len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Per-kernel-position sequencer: weight load, PE load, gap, activation load,
// execute and OFIFO->pmem drain for every kij, all on a registered inst word.
module core_seq_ctrl
  import core_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij,
  output logic [2:0]        phase
);

  phase_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic              st_go, st_cen, st_l0_wr, st_last;
  logic [AW-1:0]     st_base, st_addr;
  logic [CNT_W-1:0]  st_len;
  logic [AW-1:0]     pmem_addr;

  assign st_go     = (state_q == W_L0) || (state_q == A_L0);
  assign st_base   = (state_q == W_L0) ? W_BASE + AW'(kij_q) * AW'(COL) : A_BASE;
  assign st_len    = (state_q == W_L0) ? CNT_W'(COL) : CNT_W'(LEN_NIJ);
  assign pmem_addr = AW'(kij_q) * AW'(LEN_NIJ) + AW'(cnt_q);

  xmem_rd_stream u_xmem_rd_stream (
    .clk   (clk),
    .reset (reset),
    .go    (st_go),
    .base  (st_base),
    .len   (st_len),
    .cen   (st_cen),
    .addr  (st_addr),
    .l0_wr (st_l0_wr),
    .last  (st_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    kij_d   = kij_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inst_d  = INST_IDLE;
    inst_d[BIT_ACC]      = 1'b0;
    inst_d[BIT_IFIFO_WR] = 1'b0;
    inst_d[BIT_IFIFO_RD] = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = W_L0;
          kij_d   = '0;
          busy_d  = 1'b1;
        end
      end
      W_L0, A_L0: begin
        inst_d[BIT_CEN_XMEM]              = st_cen;
        inst_d[BIT_A_XMEM_LSB +: AW]      = st_addr;
        inst_d[BIT_L0_WR]                 = st_l0_wr;
        if (st_last) begin
          cnt_d   = '0;
          state_d = (state_q == W_L0) ? LOAD : EXEC;
        end
      end
      LOAD: begin
        inst_d[BIT_LOAD]  = 1'b1;
        inst_d[BIT_L0_RD] = (cnt_q < CNT_W'(COL));
        if (cnt_q == CNT_W'(3 * COL - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = A_L0;
        end
      end
      EXEC: begin
        inst_d[BIT_EXECUTE] = 1'b1;
        inst_d[BIT_L0_RD]   = 1'b1;
        if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // cnt only advances on a real row transfer; a stall holds the address.
        cnt_d = cnt_q;
        if (ofifo_valid) begin
          inst_d[BIT_OFIFO_RD]          = 1'b1;
          inst_d[BIT_CEN_PMEM]          = 1'b0;
          inst_d[BIT_WEN_PMEM]          = 1'b0;
          inst_d[BIT_A_PMEM_LSB +: AW]  = pmem_addr;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin
            cnt_d = '0;
            if (kij_q < 4'(LEN_KIJ - 1)) begin
              kij_d   = kij_q + 4'd1;
              state_d = W_L0;
            end else begin
              state_d = FIN;
            end
          end
        end
      end
      FIN: begin
        cnt_d   = '0;
        kij_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= INST_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign inst  = inst_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign kij   = kij_q;
  assign phase = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: reset, kij timing, drain stalls, full run,
// mid-run abort and ignored start.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        busy, done;
  logic [3:0]  kij;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic [33:0] ilog [0:159];
  logic [3:0]  klog [0:159];
  logic [2:0]  plog [0:159];

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij         (kij),
    .phase       (phase)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Start pulse at negedge s; log index i is negedge s+i.
  task automatic capture_kij0(input int pulse_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 160; i++) begin
      if (i > 1) @(negedge clk);
      ilog[i] = inst;
      klog[i] = kij;
      plog[i] = phase;
      start = (i == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic check_kij0(input string p);
    int n_cen, n_wr, n_load, n_rd, n_pw;
    n_cen = 0; n_wr = 0; n_load = 0; n_rd = 0; n_pw = 0;
    check({p, "_phase_wl0"}, plog[1], 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_axmem%0d", p, k), ilog[2+k][17:7], 64'h400 + k);
      check($sformatf("%s_cenx%0d", p, k), ilog[2+k][19], 0);
    end
    for (int i = 1; i < 21; i++) begin
      if (ilog[i][19] == 1'b0) n_cen++;
      if (ilog[i][2]  == 1'b1) n_wr++;
    end
    check({p, "_cen_count"}, n_cen, 8);
    check({p, "_l0wr_count"}, n_wr, 8);
    check({p, "_l0wr_i2"}, ilog[2][2], 0);
    check({p, "_l0wr_i3"}, ilog[3][2], 1);
    check({p, "_l0wr_i10"}, ilog[10][2], 1);
    check({p, "_l0wr_i11"}, ilog[11][2], 0);
    for (int i = 1; i < 160; i++) if (ilog[i][0]) n_load++;
    for (int i = 11; i < 35; i++) if (ilog[i][3]) n_rd++;
    check({p, "_load_count"}, n_load, 24);
    check({p, "_load_i10"}, ilog[10][0], 0);
    check({p, "_load_i11"}, ilog[11][0], 1);
    check({p, "_load_i34"}, ilog[34][0], 1);
    check({p, "_load_i35"}, ilog[35][0], 0);
    check({p, "_l0rd_load_count"}, n_rd, 8);
    check({p, "_l0rd_i18"}, ilog[18][3], 1);
    check({p, "_l0rd_i19"}, ilog[19][3], 0);
    check({p, "_exec_i83"}, ilog[83][1], 0);
    check({p, "_exec_i84"}, ilog[84][1], 1);
    check({p, "_exec_i119"}, ilog[119][1], 1);
    check({p, "_exec_i120"}, ilog[120][1], 0);
    for (int i = 1; i < 120; i++) if (ilog[i][32] == 1'b0) n_pw++;
    check({p, "_no_early_pmem"}, n_pw, 0);
    check({p, "_pmem_first_cen"}, ilog[120][32], 0);
    check({p, "_pmem_first_addr"}, ilog[120][30:20], 0);
    check({p, "_pmem_last_addr"}, ilog[155][30:20], 35);
    check({p, "_kij_i154"}, klog[154], 0);
    check({p, "_kij_i155"}, klog[155], 1);
    check({p, "_phase_i155"}, plog[155], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int guard, nwr, done_at, ndone, exp_a;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst_inst", inst, IDLE_WORD);
    check("rst_busy", busy, 0);
    check("rst_phase", phase, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_inst%0d", i), inst, IDLE_WORD);
      check($sformatf("idle_busy%0d", i), busy, 0);
      check($sformatf("idle_done%0d", i), done, 0);
      check($sformatf("idle_kij%0d", i), kij, 0);
    end

    // First kij with continuous ofifo_valid
    capture_kij0(0);
    check_kij0("k0");

    // Start pulse during LOAD is ignored
    do_reset();
    capture_kij0(20);
    check({"ign", "_phase_i20"}, plog[20], 2);
    check_kij0("ign");

    // Drain with a 5-cycle stall
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (phase !== 3'd6 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("stall_drain_reached", phase, 6);
    for (int d = 0; d < 41; d++) begin
      ofifo_valid = !(d >= 5 && d <= 9);
      @(negedge clk);
      if (d >= 5 && d <= 9) begin
        check($sformatf("stall_cenp%0d", d), inst[32], 1);
        check($sformatf("stall_ofrd%0d", d), inst[6], 0);
      end else begin
        exp_a = (d < 5) ? d : d - 5;
        check($sformatf("stall_cenp%0d", d), inst[32], 0);
        check($sformatf("stall_ofrd%0d", d), inst[6], 1);
        check($sformatf("stall_apmem%0d", d), inst[30:20], exp_a);
      end
    end
    ofifo_valid = 1'b1;
    check("stall_next_phase", phase, 1);
    check("stall_next_kij", kij, 1);

    // Full run
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nwr = 0; done_at = 0; ndone = 0;
    for (int n = 1; n < 1500; n++) begin
      if (n > 1) @(negedge clk);
      if (inst[32] == 1'b0) begin
        check($sformatf("full_apmem%0d", nwr), inst[30:20], nwr);
        check($sformatf("full_wenp%0d", nwr), inst[31], 0);
        nwr++;
      end
      if (done) begin
        done_at = n;
        ndone++;
        check("full_busy_at_done", busy, 0);
        @(negedge clk);
        check("full_done_one_cycle", done, 0);
        check("full_kij_idle", kij, 0);
        check("full_phase_idle", phase, 0);
        break;
      end
    end
    check("full_writes", nwr, 324);
    check("full_done_cycle", done_at, 1388);
    check("full_done_count", ndone, 1);

    // Reset during EXEC of kij 3
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(phase === 3'd5 && kij === 4'd3) && guard < 800) begin
      @(negedge clk);
      guard++;
    end
    check("abort_exec_kij3", {kij, phase}, {4'd3, 3'd5});
    reset = 1'b1;
    #1;
    check("abort_inst", inst, IDLE_WORD);
    check("abort_busy", busy, 0);
    check("abort_kij", kij, 0);
    @(negedge clk);
    check("abort_phase", phase, 0);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_phase", phase, 1);
    check("restart_kij", kij, 0);
    @(negedge clk);
    check("restart_axmem", inst[17:7], 64'h400);
    check("restart_cenx", inst[19], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Autonomous per-kernel-position sequencer that drives the core's 34-bit instruction word. It replaces hand-written bench stimulus.
- Precondition: activations and weights are already resident in xmem.
- For each kij it runs: weight xmem→L0, kernel load into PEs, settle gap, activation xmem→L0, execute, then OFIFO→pmem drain.
- It sits between the top-level host/start logic and `core`, and owns every instruction bit.

Parameters:
COL, 8, array columns; also weight rows per kij.
LEN_NIJ, 36, input feature-map pixels per kij.
LEN_KIJ, 9, kernel positions.
W_BASE, 11'h400, xmem address of weight rows for kij=0; kij k starts at W_BASE + k*COL.
A_BASE, 11'h000, xmem address of the first activation row.
GAP_CYC, 12, idle cycles between kernel load and activation write.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high.
start  in  1  one-cycle pulse; begins a full LEN_KIJ run when idle.
ofifo_valid  in  1  from core; OFIFO holds a readable row.
inst  out  34  core instruction word; all bits come straight from flops.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle pulse after the last pmem write of kij LEN_KIJ-1.
kij  out  4  current kernel index.
phase  out  3  current FSM state encoding.

Behaviour:
Instruction field map: acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20], CEN_xmem[19], WEN_xmem[18], A_xmem[17:7], ofifo_rd[6], ififo_wr[5], ififo_rd[4], l0_rd[3], l0_wr[2], execute[1], load[0].

Idle word INST_IDLE = 34'h1_800C_0000: CEN/WEN high, all else 0. acc, ififo_wr and ififo_rd are always 0.

Reset (async) behaviour:
- inst=INST_IDLE, busy=0, done=0, kij=0, phase=IDLE, counters=0.
- Reset mid-run aborts immediately.

FSM states (single counter `cnt`, cleared on every state entry):
- IDLE: start → W_L0, kij=0, busy=1. Start while busy is ignored.
- W_L0: COL+1 cycles.
  - cnt 0..COL-1: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*COL+cnt.
  - cnt 1..COL: l0_wr=1 (1-cycle SRAM read latency).
  - Then → LOAD.
- LOAD: 3*COL cycles, load=1; l0_rd=1 for cnt 0..COL-1 only. Then → GAP.
- GAP: GAP_CYC cycles with the idle word. Then → A_L0.
- A_L0: LEN_NIJ+1 cycles, same pattern as W_L0 but with A_xmem=A_BASE+cnt. Then → EXEC.
- EXEC: LEN_NIJ cycles, execute=1, l0_rd=1. Then → DRAIN.
- DRAIN: runs while `cnt` (row count) < LEN_NIJ.
  - If ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*LEN_NIJ+cnt, then cnt++.
  - If ofifo_valid=0: ofifo_rd=0, CEN_pmem=1 (stall, no limit).
  - After row LEN_NIJ-1: if kij<LEN_KIJ-1, kij++ and → W_L0; otherwise → FIN.
- FIN: done=1 for one cycle, busy=0, → IDLE.

Timing rules:
- Every inst bit is registered: a field value appears on inst the cycle after the FSM decides it.
- No pmem write ever occurs outside DRAIN.
- pmem address never exceeds LEN_KIJ*LEN_NIJ-1 (323 at defaults); 11-bit width is sufficient, and no wrap is permitted.
- Cycles per kij excluding stalls: (COL+1)+3COL+GAP_CYC+(LEN_NIJ+1)+2·LEN_NIJ = 154 at defaults.

Decomposition:
- Package `core_ctrl_pkg` holds:
  - the phase enum (IDLE, W_L0, LOAD, GAP, A_L0, EXEC, DRAIN, FIN);
  - instruction bit-position localparams;
  - INST_IDLE;
  - the INST_W=34 constant.
- One sub-module `xmem_rd_stream`: given base, length and go, it emits CEN/A and a one-cycle-delayed l0_wr, plus last. It is instanced once and reused by W_L0 and A_L0.

Test Plan:
1. Reset held, then released with no start → inst=34'h1800C0000, busy=0, done=0, kij=0 indefinitely.
2. start, with ofifo_valid tied 1 → W_L0 A_xmem sequence 0x400..0x407, l0_wr high 8 cycles each lagging CEN by 1; load high 24 cycles, l0_rd high in its first 8; kij advances to 1 exactly 154 cycles after W_L0 entry.
3. During DRAIN, drop ofifo_valid for cycles 5..9 → ofifo_rd=0, CEN_pmem=1 in those cycles; A_pmem resumes at 5, with no skipped or duplicated address.
4. Full run, ofifo_valid=1 → 324 pmem writes at addresses 0..323 in order; done pulses once; busy falls the same cycle; kij returns to 0 in IDLE.
5. Assert reset during EXEC of kij=3 → next cycle inst=INST_IDLE, busy=0; a new start restarts at kij=0 with A_xmem=0x400.
6. Pulse start during LOAD → no effect; cycle count and addresses identical to scenario 2.
